mcb_port_responder: RTL
=======================

MCB_PORT_RESPONDER -- requirements
Module: mcb_port_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning backing-store depth in 32-bit words (power of two).
REQ-002 SHALL have parameter RD_LATENCY, default 4, meaning cycles from read-command pop to first read-FIFO push.
REQ-003 SHALL have parameter CALIB_CYCLES, default 16, meaning cycles after reset release before calib_done rises.
REQ-004 SHALL have the port clk, input, 1 bit: the single clock for all logic, including command, write and read ports.
REQ-005 SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have cmd_en in 1 and cmd_instr in 3 (0=WRITE, 1=READ, 4=REFRESH).
REQ-007 SHALL have cmd_bl in 6 (words minus 1) and cmd_byte_addr in 30.
REQ-008 SHALL have cmd_empty out 1 and cmd_full out 1.
REQ-009 SHALL have wr_en in 1, wr_mask in 4 (1=byte not written) and wr_data in 32.
REQ-010 SHALL have wr_full out 1, wr_empty out 1, wr_count out 7, wr_underrun out 1 and wr_error out 1.
REQ-011 SHALL have rd_en in 1, rd_data out 32, rd_full out 1, rd_empty out 1 and rd_count out 7.
REQ-012 SHALL have rd_overflow out 1, rd_error out 1 and calib_done out 1.

Function
REQ-013 SHALL hold a 4-entry command FIFO; a cmd_en push while cmd_full SHALL be dropped.
REQ-014 SHALL hold a 64-word write FIFO storing {mask,data}; a wr_en push while wr_full SHALL be dropped and set sticky wr_error.
REQ-015 SHALL hold a 64-word first-word-fall-through read FIFO: rd_data is valid whenever rd_empty=0, and rd_en pops it.
REQ-016 SHALL set sticky rd_error on rd_en while rd_empty, with no pop.
REQ-017 SHALL keep counts unchanged when a push and a pop occur in the same cycle; wr_count and rd_count SHALL range 0..64.
REQ-018 SHALL derive the word address as cmd_byte_addr[2+log2(MEM_WORDS)-1:2]; burst words SHALL increment by 1 and wrap modulo MEM_WORDS.
REQ-019 SHALL run an execution FSM with states IDLE, WR_BURST, RD_WAIT, RD_BURST and REF_WAIT.
REQ-020 IDLE: while calib_done=1 and the command FIFO is non-empty, SHALL pop one command; WRITE->WR_BURST, READ->RD_WAIT, REFRESH->REF_WAIT, other codes SHALL be discarded (stay in IDLE).
REQ-021 WR_BURST: SHALL retire one word per cycle, for bl+1 cycles, popping the write FIFO and writing unmasked bytes.
REQ-022 WR_BURST: if the write FIFO is empty when a word is due, SHALL write nothing for that word, set sticky wr_underrun and advance anyway.
REQ-023 RD_WAIT: SHALL wait RD_LATENCY cycles, then go to RD_BURST.
REQ-024 RD_BURST: SHALL push one memory word per cycle, for bl+1 cycles; a push while rd_full SHALL drop that word and set sticky rd_overflow.
REQ-025 REF_WAIT: SHALL idle 8 cycles with no memory access.
REQ-026 A read SHALL observe all writes from earlier-popped commands (in-order, no reordering).
REQ-027 Sticky flags SHALL clear only on reset.
REQ-028 calib_done SHALL rise exactly CALIB_CYCLES cycles after rst_n deasserts and SHALL stay high.
REQ-029 Commands accepted before calib_done SHALL be queued and executed after calib_done rises.

Reset
REQ-030 On rst_n=0 the block SHALL asynchronously empty all FIFOs and enter IDLE.
REQ-031 On reset: cmd_empty=1, wr_empty=1, rd_empty=1, cmd_full=0, wr_full=0, rd_full=0, counts=0, all sticky flags=0, calib_done=0, rd_data=0.
REQ-032 Backing-store contents SHALL NOT be reset.
REQ-033 Reset mid-burst SHALL abort the burst with no further memory writes.

Structure
REQ-034 Instruction codes, FIFO depths and FSM state encodings SHALL live in the shared package mcb_pkg.
REQ-035 The three FIFOs SHALL be instances of one parameterised sub-module mcb_sync_fifo (width, depth, count, full/empty).

Verification
REQ-036 After reset, SHALL check calib_done=0 for 16 cycles, then 1, with all empties=1.
REQ-037 Push 2 words (A5A5A5A5, 5A5A5A5A), WRITE bl=1 addr 0x40, then READ bl=1 addr 0x40 -> rd_data A5A5A5A5 then 5A5A5A5A; rd_empty=1 after two pops.
REQ-038 Write FFFFFFFF to addr 0, then write 00000000 with mask 4'b1100, then read addr 0 -> FFFF0000.
REQ-039 WRITE bl=0 with write FIFO empty -> wr_underrun=1 and memory unchanged; rd_en on an empty read FIFO -> rd_error=1.
REQ-040 Two READ bl=63 commands without popping -> 64 words held, rd_full=1, rd_overflow=1.
REQ-041 WRITE bl=1 at the last word (byte addr 4*1023) -> second word lands at word 0; assert rst_n low mid-burst -> all FIFOs empty and FSM in IDLE.

Source files
------------

// File: rtl/mcb_pkg.sv
// Shared encodings for the MCB port responder: command codes, FIFO depths, FSM states.
// Pure declarations; no logic, no latency, no flow control.
package mcb_pkg;

    localparam logic [2:0] CMD_WRITE   = 3'd0;
    localparam logic [2:0] CMD_READ    = 3'd1;
    localparam logic [2:0] CMD_REFRESH = 3'd4;

    localparam int CMD_FIFO_DEPTH  = 4;
    localparam int DATA_FIFO_DEPTH = 64;
    localparam int REF_CYCLES      = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_BURST = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_RD_BURST = 3'd3;
    localparam logic [2:0] ST_REF_WAIT = 3'd4;

    typedef struct packed {
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [29:0] byte_addr;
    } cmd_t;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
    } wr_word_t;

endpackage

// File: rtl/mcb_sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count; dout is valid whenever empty=0.
// Push while full and pop while empty are ignored; pointers and count reset asynchronously.
module mcb_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mcb_port_responder.sv
// Single-port memory-controller-block responder: queued commands execute in order against a word store.
// Read data appears RD_LATENCY cycles after command pop; full FIFOs drop pushes and raise sticky flags.
module mcb_port_responder
    import mcb_pkg::*;
#(
    parameter int MEM_WORDS    = 1024,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_en,
    input  logic [2:0]  cmd_instr,
    input  logic [5:0]  cmd_bl,
    input  logic [29:0] cmd_byte_addr,
    output logic        cmd_empty,
    output logic        cmd_full,
    input  logic        wr_en,
    input  logic [3:0]  wr_mask,
    input  logic [31:0] wr_data,
    output logic        wr_full,
    output logic        wr_empty,
    output logic [6:0]  wr_count,
    output logic        wr_underrun,
    output logic        wr_error,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_full,
    output logic        rd_empty,
    output logic [6:0]  rd_count,
    output logic        rd_overflow,
    output logic        rd_error,
    output logic        calib_done
);
    localparam int AW  = $clog2(MEM_WORDS);
    localparam int CCW = $clog2(CMD_FIFO_DEPTH + 1);
    localparam int KW  = $clog2(CALIB_CYCLES + 1);

    logic [31:0]    mem [MEM_WORDS];
    logic [2:0]     state;
    logic [AW-1:0]  word_addr;
    logic [5:0]     beats_left;
    logic [7:0]     wait_cnt;
    logic [KW-1:0]  calib_cnt;

    cmd_t           cmd_q;
    wr_word_t       wr_q;
    logic [31:0]    rd_q;
    logic [CCW-1:0] cmd_count;
    logic           cmd_pop;
    logic           wr_pop;
    logic           mem_we;
    logic           rd_push;
    logic           unused_addr_bits;

    mcb_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
        .clk(clk), .rst_n(rst_n), .push(cmd_en), .pop(cmd_pop),
        .din({cmd_instr, cmd_bl, cmd_byte_addr}), .dout(cmd_q),
        .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
    );

    mcb_sync_fifo #(.WIDTH($bits(wr_word_t)), .DEPTH(DATA_FIFO_DEPTH)) u_wr_fifo (
        .clk(clk), .rst_n(rst_n), .push(wr_en), .pop(wr_pop),
        .din({wr_mask, wr_data}), .dout(wr_q),
        .full(wr_full), .empty(wr_empty), .count(wr_count)
    );

    mcb_sync_fifo #(.WIDTH(32), .DEPTH(DATA_FIFO_DEPTH)) u_rd_fifo (
        .clk(clk), .rst_n(rst_n), .push(rd_push), .pop(rd_en),
        .din(mem[word_addr]), .dout(rd_q),
        .full(rd_full), .empty(rd_empty), .count(rd_count)
    );

    // Only the word-index bits of the byte address select storage.
    assign unused_addr_bits = ^{cmd_q.byte_addr[29:AW+2], cmd_q.byte_addr[1:0]};

    assign calib_done = (calib_cnt == KW'(CALIB_CYCLES));
    assign cmd_pop    = (state == ST_IDLE) && calib_done && (cmd_count != '0);
    assign wr_pop     = (state == ST_WR_BURST);
    assign mem_we     = (state == ST_WR_BURST) && !wr_empty;
    assign rd_push    = (state == ST_RD_BURST);
    assign rd_data    = rd_empty ? 32'h0 : rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calib_cnt <= '0;
        end else if (!calib_done) begin
            calib_cnt <= calib_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            word_addr  <= '0;
            beats_left <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_pop) begin
                        word_addr  <= cmd_q.byte_addr[AW+1:2];
                        beats_left <= cmd_q.bl;
                        case (cmd_q.instr)
                            CMD_WRITE: state <= ST_WR_BURST;
                            CMD_READ: begin
                                // The pop cycle itself counts toward the read latency.
                                state    <= (RD_LATENCY > 1) ? ST_RD_WAIT : ST_RD_BURST;
                                wait_cnt <= 8'(RD_LATENCY - 2);
                            end
                            CMD_REFRESH: begin
                                state    <= ST_REF_WAIT;
                                wait_cnt <= 8'(REF_CYCLES - 1);
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_WR_BURST, ST_RD_BURST: begin
                    word_addr <= word_addr + 1'b1;
                    if (beats_left == '0) state <= ST_IDLE;
                    else beats_left <= beats_left - 1'b1;
                end
                ST_RD_WAIT: begin
                    if (wait_cnt == '0) state <= ST_RD_BURST;
                    else wait_cnt <= wait_cnt - 1'b1;
                end
                ST_REF_WAIT: begin
                    if (wait_cnt == '0) state <= ST_IDLE;
                    else wait_cnt <= wait_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_underrun <= 1'b0;
            wr_error    <= 1'b0;
            rd_overflow <= 1'b0;
            rd_error    <= 1'b0;
        end else begin
            if ((state == ST_WR_BURST) && wr_empty) wr_underrun <= 1'b1;
            if (wr_en && wr_full)                   wr_error    <= 1'b1;
            if (rd_push && rd_full)                 rd_overflow <= 1'b1;
            if (rd_en && rd_empty)                  rd_error    <= 1'b1;
        end
    end

    // Backing store is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (!wr_q.mask[b]) mem[word_addr][8*b +: 8] <= wr_q.data[8*b +: 8];
            end
        end
    end

endmodule
